// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the byte-serial instruction fetch unit:
// bus widths, reset constants, fetch state encoding and lane helper.
package pc_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic              RstEnable  = 1'b1;
    localparam logic [InstBus-1:0] ZeroWord  = 32'h0000_0000;
    localparam logic [InstAddrBus-1:0] DefResetPc = 32'h0000_0000;

    localparam logic [2:0] BytesPerInst = 3'd4;
    localparam logic [2:0] LastLane     = 3'd3;
    localparam logic [InstAddrBus-1:0] InstStep = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_e;

    // Little-endian lane insert: lane 0 is bits 7:0.
    function automatic logic [InstBus-1:0] put_lane(
        input logic [InstBus-1:0] word,
        input logic [1:0]         lane,
        input logic [7:0]         data
    );
        logic [InstBus-1:0] w_res;
        w_res = word;
        unique case (lane)
            2'd0: w_res[7:0]   = data;
            2'd1: w_res[15:8]  = data;
            2'd2: w_res[23:16] = data;
            2'd3: w_res[31:24] = data;
            default: w_res = word;
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/pc_fetch.sv
// Byte-serial instruction fetch: issues four pipelined byte reads per
// instruction, assembles them and holds the word until consumed.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = DefResetPc
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch_i,
    input  logic [InstAddrBus-1:0] branch_addr_i,
    input  logic                   stall_i,
    input  logic                   mem_grant_i,
    input  logic [7:0]             mem_data_i,
    output logic                   mem_re_o,
    output logic [InstAddrBus-1:0] mem_addr_o,
    output logic                   inst_valid_o,
    output logic [InstBus-1:0]     inst_o,
    output logic [InstAddrBus-1:0] inst_pc_o
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [InstAddrBus-1:0] r_pc;
    logic [2:0]             r_req_cnt;
    logic [2:0]             r_rcv_cnt;
    logic                   r_pending;
    logic [InstBus-1:0]     r_buf;

    logic w_in_rst;
    logic w_fetching;
    logic w_req;
    logic w_grant;
    logic w_capture;
    logic w_last;
    logic w_advance;
    logic w_valid;

    assign w_in_rst   = (rst == RstEnable);
    assign w_fetching = (r_state == ST_FETCH);
    assign w_req      = w_fetching && (r_req_cnt < BytesPerInst)
                        && !branch_i && !w_in_rst;
    assign w_grant    = w_req && mem_grant_i;
    // A redirect drops whatever byte is returning this cycle.
    assign w_capture  = w_fetching && r_pending && !branch_i;
    assign w_last     = w_capture && (r_rcv_cnt == LastLane);
    assign w_advance  = (r_state == ST_DONE) && !stall_i && !branch_i;
    assign w_valid    = (r_state == ST_DONE) && !w_in_rst;

    always_comb begin
        w_state_nxt = r_state;
        if (branch_i) begin
            w_state_nxt = ST_FETCH;
        end else begin
            unique case (r_state)
                ST_IDLE:  w_state_nxt = ST_FETCH;
                ST_FETCH: if (w_last) w_state_nxt = ST_DONE;
                ST_DONE:  if (!stall_i) w_state_nxt = ST_FETCH;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_rst) begin
            r_pc      <= RESET_PC;
            r_req_cnt <= 3'd0;
            r_rcv_cnt <= 3'd0;
            r_pending <= 1'b0;
            r_buf     <= ZeroWord;
        end else if (branch_i) begin
            r_pc      <= branch_addr_i;
            r_req_cnt <= 3'd0;
            r_rcv_cnt <= 3'd0;
            r_pending <= 1'b0;
        end else if (w_advance) begin
            r_pc      <= r_pc + InstStep;
            r_req_cnt <= 3'd0;
            r_rcv_cnt <= 3'd0;
            r_pending <= 1'b0;
        end else if (w_fetching) begin
            // Grant and return can overlap, keeping one byte in flight.
            r_pending <= w_grant;
            if (w_grant) begin
                r_req_cnt <= r_req_cnt + 3'd1;
            end
            if (w_capture) begin
                r_buf     <= put_lane(r_buf, r_rcv_cnt[1:0], mem_data_i);
                r_rcv_cnt <= r_rcv_cnt + 3'd1;
            end
        end
    end

    assign mem_re_o     = w_req;
    assign mem_addr_o   = w_req ? (r_pc + {29'd0, r_req_cnt}) : ZeroWord;
    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? r_buf : ZeroWord;
    assign inst_pc_o    = w_valid ? r_pc : ZeroWord;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios then random
// traffic, compared each cycle against a transaction-level model.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        mem_grant_i = 1'b0;
    logic [7:0]  mem_data_i = 8'h0;
    logic        mem_re_o;
    logic [31:0] mem_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    int checks = 0;
    int errors = 0;

    pc_fetch #(.RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .stall_i       (stall_i),
        .mem_grant_i   (mem_grant_i),
        .mem_data_i    (mem_data_i),
        .mem_re_o      (mem_re_o),
        .mem_addr_o    (mem_addr_o),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o)
    );

    always #5 clk = ~clk;

    // Byte-addressed memory image: 0..3 hold 13 00 50 00.
    function automatic logic [7:0] memb(input logic [31:0] a);
        logic [7:0] r;
        case (a)
            32'd0:   r = 8'h13;
            32'd1:   r = 8'h00;
            32'd2:   r = 8'h50;
            32'd3:   r = 8'h00;
            default: r = a[7:0] ^ (a[15:8] * 8'd3) ^ a[31:24] ^ 8'h5A;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {memb(a + 32'd3), memb(a + 32'd2),
                memb(a + 32'd1), memb(a)};
    endfunction

    // Reference model: phase flags, target pc, bytes asked/received.
    bit          m_idle = 1'b1;
    bit          m_ready = 1'b0;
    logic [31:0] m_pc = 32'h0;
    int          m_asked = 0;
    int          m_got = 0;
    bit          m_inflight = 1'b0;

    // Memory responder state.
    bit          ret_pend = 1'b0;
    logic [31:0] ret_addr = 32'h0;

    // Last sampled DUT outputs.
    logic        s_re;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_inst;
    logic [31:0] s_ipc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit br, input logic [31:0] ba,
                       input bit st, input bit gr, input bit rs);
        bit          e_re;
        logic [31:0] e_addr;
        bit          fetching;
        @(negedge clk);
        rst           = rs;
        branch_i      = br;
        branch_addr_i = ba;
        stall_i       = st;
        mem_grant_i   = gr;
        mem_data_i    = ret_pend ? memb(ret_addr) : 8'($urandom);
        #1;
        fetching = !m_idle && !m_ready;
        e_re   = !rs && fetching && (m_asked < 4) && !br;
        e_addr = e_re ? m_pc + 32'(m_asked) : 32'h0;
        s_re    = mem_re_o;
        s_addr  = mem_addr_o;
        s_valid = inst_valid_o;
        s_inst  = inst_o;
        s_ipc   = inst_pc_o;
        chk("mem_re", 32'(s_re), 32'(e_re));
        chk("mem_addr", s_addr, e_addr);
        chk("inst_valid", 32'(s_valid), 32'(!rs && m_ready));
        if (rs) begin
            chk("inst_rst", s_inst, 32'h0);
            chk("inst_pc_rst", s_ipc, 32'h0);
        end else if (m_ready) begin
            chk("inst", s_inst, word_at(m_pc));
            chk("inst_pc", s_ipc, m_pc);
        end
        @(posedge clk);
        ret_pend = e_re && gr;
        ret_addr = e_addr;
        if (rs) begin
            m_idle = 1; m_ready = 0; m_pc = 32'h0;
            m_asked = 0; m_got = 0; m_inflight = 0;
        end else if (br) begin
            m_idle = 0; m_ready = 0; m_pc = ba;
            m_asked = 0; m_got = 0; m_inflight = 0;
        end else if (m_idle) begin
            m_idle = 0;
        end else if (m_ready) begin
            if (!st) begin
                m_ready = 0; m_pc = m_pc + 32'd4;
                m_asked = 0; m_got = 0; m_inflight = 0;
            end
        end else begin
            if (m_inflight) m_got++;
            m_inflight = e_re && gr;
            if (e_re && gr) m_asked++;
            if (m_got == 4) m_ready = 1;
        end
    endtask

    // Stall held high so the DUT stays in DONE once valid is seen.
    task automatic wait_valid(input bit rg, input int maxc, output int n);
        n = 0;
        do begin
            cyc(0, 32'h0, 1, rg ? 1'($urandom_range(0, 1)) : 1'b1, 0);
            n++;
        end while (!s_valid && n < maxc);
        chk("wait_valid", 32'(s_valid), 32'h1);
    endtask

    initial begin
        int n;
        logic [31:0] ba;

        cyc(0, 32'h0, 0, 1, 1);
        cyc(0, 32'h0, 0, 1, 1);
        cyc(0, 32'h0, 1, 1, 0);
        chk("idle_no_req", 32'(s_re), 32'h0);

        wait_valid(0, 12, n);
        chk("first_latency", 32'(n), 32'd6);
        chk("first_inst", s_inst, 32'h0050_0013);
        chk("first_pc", s_ipc, 32'h0);

        cyc(0, 32'h0, 1, 1, 0);
        cyc(0, 32'h0, 1, 1, 0);
        cyc(0, 32'h0, 0, 1, 0);
        chk("stall_hold", s_inst, 32'h0050_0013);
        cyc(0, 32'h0, 1, 1, 0);
        chk("next_addr4", s_addr, 32'h4);

        for (int k = 0; k < 3; k++) begin
            cyc(0, 32'h0, 1, (k == 2), 0);
            chk("grant_hold", s_addr, 32'h5);
        end
        wait_valid(0, 12, n);
        chk("slow_latency", 32'(n), 32'd4);
        chk("slow_inst", s_inst, word_at(32'h4));

        cyc(0, 32'h0, 0, 1, 0);
        cyc(0, 32'h0, 0, 1, 0);
        cyc(0, 32'h0, 0, 1, 0);
        cyc(1, 32'h100, 0, 1, 0);
        chk("branch_no_req", 32'(s_re), 32'h0);
        cyc(0, 32'h0, 1, 1, 0);
        chk("branch_addr", s_addr, 32'h100);
        wait_valid(0, 12, n);
        chk("branch_pc", s_ipc, 32'h100);

        cyc(1, 32'h200, 1, 1, 0);
        cyc(0, 32'h0, 1, 1, 0);
        chk("brstall_valid", 32'(s_valid), 32'h0);
        chk("brstall_addr", s_addr, 32'h200);
        wait_valid(1, 40, n);

        cyc(1, 32'hFFFF_FFFC, 0, 1, 0);
        wait_valid(0, 12, n);
        chk("wrap_pc", s_ipc, 32'hFFFF_FFFC);
        cyc(0, 32'h0, 0, 1, 0);
        cyc(0, 32'h0, 1, 1, 0);
        chk("wrap_addr0", s_addr, 32'h0);

        cyc(0, 32'h0, 1, 1, 0);
        cyc(1, 32'h40, 1, 1, 0);
        cyc(0, 32'h0, 1, 1, 0);
        cyc(0, 32'h0, 1, 1, 1);
        cyc(0, 32'h0, 1, 1, 0);
        chk("post_rst_idle", 32'(s_re), 32'h0);
        wait_valid(0, 12, n);
        chk("post_rst_inst", s_inst, 32'h0050_0013);

        for (int k = 0; k < 3000; k++) begin
            ba = ($urandom_range(0, 3) == 0)
                 ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                 : $urandom;
            cyc($urandom_range(0, 19) == 0, ba,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 branch_i  input  1  redirect request from execute stage.
REQ-005 branch_addr_i  input  32  redirect target PC.
REQ-006 stall_i  input  1  IF/ID not ready; held instruction is not consumed.
REQ-007 mem_grant_i  input  1  memory port accepts this cycle's byte request.
REQ-008 mem_data_i  input  8  read byte, valid exactly one cycle after a granted request.
REQ-009 mem_re_o  output  1  byte read request.
REQ-010 mem_addr_o  output  32  byte address of the request.
REQ-011 inst_valid_o  output  1  inst_o/inst_pc_o hold a complete instruction.
REQ-012 inst_o  output  32  assembled instruction word.
REQ-013 inst_pc_o  output  32  PC of inst_o.

Function
REQ-014 The block SHALL have states IDLE, FETCH and DONE, plus a 32-bit pc, a 3-bit req_cnt, a 3-bit rcv_cnt and a 1-bit pending flag.
REQ-015 Transitions: IDLE->FETCH unconditionally; FETCH->DONE when the fourth byte is captured; DONE->FETCH when stall_i=0 and branch_i=0; any state->FETCH on branch_i=1.
REQ-016 In FETCH, mem_re_o SHALL be 1 while req_cnt<4 and branch_i=0, with mem_addr_o = pc + req_cnt (modulo 2^32).
REQ-017 A request with mem_grant_i=0 SHALL be held unchanged; req_cnt SHALL increment and pending SHALL be set only on a granted cycle.
REQ-018 When pending=1, mem_data_i SHALL be written to byte lane rcv_cnt of the instruction buffer (lane 0 = bits 7:0, little-endian), and rcv_cnt SHALL increment.
REQ-019 Requests SHALL be pipelined: a new byte may be granted in the same cycle the previous byte returns. Best-case fetch latency is 5 cycles from entering FETCH to inst_valid_o=1.
REQ-020 In DONE, inst_valid_o=1, inst_o=buffer and inst_pc_o=pc. mem_re_o SHALL be 0.
REQ-021 On leaving DONE with stall_i=0, pc SHALL become pc+4 (wraps at 2^32), the counters SHALL clear, and inst_valid_o SHALL be 0 in the next cycle.
REQ-022 On branch_i=1 in any cycle, the block SHALL:
- drop any byte returning that cycle;
- force mem_re_o=0 that cycle;
- load pc with branch_addr_i;
- clear req_cnt, rcv_cnt and pending;
- enter FETCH.
inst_valid_o SHALL be 0 from the next cycle.
REQ-023 branch_i and stall_i both high: branch wins and the held instruction is discarded.
REQ-024 stall_i SHALL NOT affect the FETCH state; it acts only in DONE.
REQ-025 mem_addr_o SHALL be 0 whenever mem_re_o=0.

Reset
REQ-026 rst=1 at a clock edge SHALL set:
- state=IDLE and pc=RESET_PC;
- req_cnt=0, rcv_cnt=0, pending=0, buffer=0.
REQ-027 During reset, mem_re_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0 and inst_pc_o=0.
REQ-028 Reset asserted mid-fetch SHALL abandon the fetch. A byte returning after reset deasserts SHALL be ignored (pending already cleared).
REQ-029 The first request SHALL issue in the second cycle after rst deasserts (IDLE->FETCH).

Structure
REQ-030 Shared define file SHALL hold InstAddrBus, InstBus, RstEnable, ZeroWord, fetch state encodings and the default reset PC.
REQ-031 The block SHALL be a single module with no sub-module. Byte assembly and the PC register are inline.

Verification
REQ-032 Reset, grant always 1, memory 0..3 = 13 00 50 00 -> four requests at addresses 0,1,2,3; inst_valid_o=1 with inst_o=32'h0050_0013 and inst_pc_o=0, 5 cycles after the first request.
REQ-033 Grant low for 2 cycles on byte 1 -> mem_addr_o held at 1 for 3 cycles; the final inst_o is unchanged; latency grows by 2.
REQ-034 stall_i=1 for 3 cycles in DONE -> inst_o/inst_pc_o stable for 4 cycles; then pc=4 and the next requests go to 4..7.
REQ-035 branch_i=1 with branch_addr_i=32'h100 after 2 bytes granted -> mem_re_o=0 that cycle; the byte returning that cycle is dropped; the next request is addr 0x100; inst_pc_o=0x100.
REQ-036 branch_i and stall_i high together in DONE -> inst_valid_o=0 next cycle and fetch restarts at branch_addr_i.
REQ-037 pc=32'hFFFF_FFFC, stall_i=0 -> requests FFFF_FFFC..FFFF_FFFF, then wrap to 0..3.
